mem_burst_reader: RTL and testbench

Burst read engine sitting directly downstream of the single-port memory unit. It accepts a (base address, length) command and drives the memory's read request/address at up to one word per cycle. It captures the memory's registered read data, which arrives 1 cycle after the request, and presents it as a valid/ready stream with a last-beat marker. A 2-entry buffer absorbs consumer backpressure without losing any word already requested from memory.

---
 rtl/mem_rd_pkg.sv | 8 +
 rtl/mem_rd_skid_buf.sv | 39 +++
 rtl/mem_burst_reader.sv | 112 +++++++++++
 tb/tb_mem_burst_reader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg: shared types and constants for mem_burst_reader
package mem_rd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} mem_rd_state_e;
  localparam int RdBufDepth = 2;
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/mem_rd_skid_buf.sv
// mem_rd_skid_buf: 2-entry FIFO, head always in e0 so the output stays stable under backpressure
module mem_rd_skid_buf
  import mem_rd_pkg::*;
#(
  parameter int Width = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic [1:0]       occ
);
  logic [Width-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] occ_q, occ_d, slot;
  always_comb begin
    e0_d = pop ? e1_q : e0_q;
    e1_d = e1_q;
    slot = occ_q - 2'(pop);
    if (push && slot == 2'd0) e0_d = din;
    if (push && slot != 2'd0) e1_d = din;
    occ_d = flush ? 2'd0 : occ_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end
  assign dout = e0_q;
  assign occ  = occ_q;
endmodule

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: issues burst reads to a 1-cycle-latency memory and streams the words out.
// Optional abort port pair enabled by MEM_BURST_READER_ABORT_EN.
module mem_burst_reader
  import mem_rd_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int MemDepth  = 256,
  parameter int LenWidth  = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_addr,
  input  logic [LenWidth-1:0]  cmd_len,
  output logic                 mem_rd_req,
  output logic [31:0]          mem_rd_addr,
  input  logic [DataWidth-1:0] mem_data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_last,
`ifdef MEM_BURST_READER_ABORT_EN
  input  logic                 abort,
  output logic                 aborted,
`endif
  output logic                 done
);
  localparam int AW = idx_w(MemDepth);
  mem_rd_state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LenWidth-1:0] rem_q, rem_d;
  logic rd_pend_q, rd_pend_d, rd_last_q, rd_last_d, done_q, done_d;
  logic issue, pop, abort_hit, unused_addr_hi;
  logic [1:0] occ;
  assign pop = out_valid && out_ready;
  assign unused_addr_hi = ^cmd_addr[31:AW];
  // credit rule: buffered + in-flight words after this cycle never exceed the buffer depth
  assign issue = state_q == RUN && !abort_hit &&
                 (3'(occ) + 3'(rd_pend_q) < 3'(RdBufDepth) + 3'(pop));
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    rd_pend_d = issue;
    rd_last_d = issue && rem_q == LenWidth'(1);
    if (state_q == IDLE && cmd_valid) begin
      addr_d  = cmd_addr[AW-1:0];
      rem_d   = cmd_len;
      state_d = cmd_len != '0 ? RUN : IDLE;
      done_d  = cmd_len == '0;
    end
    if (issue) begin
      addr_d  = addr_q + 1'b1;
      rem_d   = rem_q - 1'b1;
      state_d = rem_q == LenWidth'(1) ? DRAIN : RUN;
    end
    if (state_q == DRAIN && pop && out_last) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    if (abort_hit) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
      done_q    <= done_d;
    end
  end
`ifdef MEM_BURST_READER_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_hit = abort && state_q != IDLE;
  assign aborted_d = abort_hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted_q <= 1'b0;
    else aborted_q <= aborted_d;
  end
  assign aborted = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif
  mem_rd_skid_buf #(.Width(DataWidth + 1)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pend_q && !abort_hit),
    .pop   (pop),
    .flush (abort_hit),
    .din   ({rd_last_q, mem_data_in}),
    .dout  ({out_last, out_data}),
    .occ   (occ)
  );
  assign out_valid   = occ != 2'd0;
  assign cmd_ready   = state_q == IDLE;
  assign mem_rd_req  = issue;
  assign mem_rd_addr = {{(32 - AW){1'b0}}, addr_q};
  assign done        = done_q;
endmodule

// File: tb/tb_mem_burst_reader.sv
// tb_mem_burst_reader: table-driven, hand-written and random bursts against a queue-based stream model
module tb_mem_burst_reader;
  logic clk = 0, rst_n = 0, cmd_valid = 0, out_ready = 1;
  logic [31:0] cmd_addr = 0;
  logic [8:0] cmd_len = 0;
  logic mem_rd_req, cmd_ready, out_valid, out_last, done;
  logic [31:0] mem_rd_addr, mem_data_in = 0, out_data;
  logic [31:0] mem [256];
  int n_chk = 0, n_pass = 0;
`ifdef MEM_BURST_READER_ABORT_EN
  logic abort = 0, aborted;
`endif

  mem_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_rd_req(mem_rd_req),
    .mem_rd_addr(mem_rd_addr), .mem_data_in(mem_data_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
`ifdef MEM_BURST_READER_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_req) mem_data_in <= mem[mem_rd_addr[7:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rd_req"}, mem_rd_req, 0);
    chk({tag, "_rd_addr"}, mem_rd_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  function automatic logic rdy(input int mode, input int k);
    return mode == 0 ? 1'b1 : mode == 1 ? !(k >= 3 && k <= 10) : ($urandom_range(0, 3) != 0);
  endfunction

  // k counts cycles after the handshake cycle T, so cycle T+k is iteration k
  task automatic run_burst(input logic [31:0] a, input int n, input int mode, input int rst_at,
                           output logic [31:0] first_d, output logic [31:0] last_d,
                           output int first_k, output int done_k);
    logic [31:0] exp_q[$];
    logic [31:0] held = 0;
    int nreq = 0, nbeat = 0, k = 1, max_out = 0;
    bit stalled = 0, got_done = 0;
    first_d = 0; last_d = 0; first_k = -1; done_k = -1;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(int'(a) + i) & 255]);
    @(negedge clk);
    cmd_addr = a; cmd_len = 9'(n); cmd_valid = 1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 0; out_ready = rdy(mode, 1);
    while (k < 300) begin
      @(negedge clk);
      if (got_done) begin
        chk("done_one_cycle", done, 0);
        break;
      end
      if (k == rst_at) begin
        rst_n = 0;
        #1 chk_reset_vals("midrst");
        return;
      end
      if (mem_rd_req) begin
        chk("rd_addr", mem_rd_addr, (int'(a) + nreq) & 255);
        nreq++;
      end
      if (stalled) chk("stall_stable", {out_valid, out_last, out_data}, {1'b1, held[0+:1] & 1'b0 | out_last, held});
      if (out_valid && out_ready) begin
        if (nbeat < n) begin
          chk("beat_data", out_data, exp_q[nbeat]);
          chk("beat_last", out_last, nbeat == n - 1);
        end else chk("beat_overrun", nbeat + 1, n);
        if (nbeat == 0) begin first_d = out_data; first_k = k; end
        last_d = out_data;
        nbeat++;
      end
      if (nreq - nbeat > max_out) max_out = nreq - nbeat;
      if (done) begin
        done_k = k; got_done = 1;
        chk("done_beats", nbeat, n);
        chk("done_reqs", nreq, n);
        chk("done_cmd_ready", cmd_ready, 1);
        chk("outstanding_le2", max_out <= 2, 1);
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      @(posedge clk);
      #1 k++; out_ready = rdy(mode, k);
    end
    chk("done_seen", got_done, 1);
    out_ready = 1;
  endtask

  typedef struct {
    logic [31:0] addr; int len;
    logic [31:0] first; logic [31:0] last; int first_k; int done_k;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [31:0] fd, ld;
    int fk, dk, spurious;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 'h100);
    tbl[0] = '{'h10, 4, 'h110, 'h113, 3, 7};
    tbl[1] = '{254, 4, 'h1fe, 'h101, 3, 7};
    tbl[2] = '{0, 1, 'h100, 'h100, 3, 4};
    tbl[3] = '{255, 2, 'h1ff, 'h100, 3, 5};
    tbl[4] = '{'h120, 3, 'h120, 'h122, 3, 6};
    tbl[5] = '{'h42, 0, 0, 0, -1, 1};
    #12 chk_reset_vals("reset");
    @(negedge clk) rst_n = 1;
    for (int t = 0; t < 6; t++) begin
      run_burst(tbl[t].addr, tbl[t].len, 0, 0, fd, ld, fk, dk);
      chk($sformatf("vec%0d_first", t), fd, tbl[t].first);
      chk($sformatf("vec%0d_last", t), ld, tbl[t].last);
      chk($sformatf("vec%0d_first_k", t), fk, tbl[t].first_k);
      chk($sformatf("vec%0d_done_k", t), dk, tbl[t].done_k);
    end
    run_burst('h30, 8, 1, 0, fd, ld, fk, dk);
    chk("stall_first", fd, 'h130);
    chk("stall_last", ld, 'h137);
    run_burst('h50, 6, 0, 5, fd, ld, fk, dk);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    spurious = 0;
    repeat (4) @(negedge clk) spurious += int'(done) + int'(out_valid) + int'(mem_rd_req);
    chk("post_reset_quiet", spurious, 0);
    run_burst('h60, 2, 0, 0, fd, ld, fk, dk);
    chk("post_reset_first", fd, 'h160);
    chk("post_reset_done_k", dk, 5);
`ifdef MEM_BURST_READER_ABORT_EN
    @(negedge clk);
    cmd_addr = 0; cmd_len = 10; cmd_valid = 1;
    @(posedge clk);
    #1 cmd_valid = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 abort = 1;
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    chk("abort_done", done, 1);
    chk("abort_aborted", aborted, 1);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk);
    chk("abort_pulse_end", {done, aborted}, 0);
`endif
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int r = 0; r < 25; r++)
      run_burst($urandom_range(0, 511), $urandom_range(0, 20), 2, 0, fd, ld, fk, dk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
